// File: rtl/mult2_fitness_scorer.sv
// Fitness scorer for evolved 2x2-bit multipliers: compares packed candidate
// product words lane by lane against the true product and keeps the best score.
//
// state | meaning
// IDLE  | waiting for a candidate, in_ready high
// SCORE | one product word compared per cycle, step 0..3
// DONE  | score held on out_valid until out_ready
module mult2_fitness_scorer #(
  parameter int W  = 16,
  parameter int SW = $clog2(4*W+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_best,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  b1,
  input  logic [W-1:0]  b0,
  input  logic [W-1:0]  y3,
  input  logic [W-1:0]  y2,
  input  logic [W-1:0]  y1,
  input  logic [W-1:0]  y0,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] score,
  output logic          perfect,
  output logic [SW-1:0] best_score,
  output logic [15:0]   best_idx,
  output logic [15:0]   ind_idx
);

  typedef enum logic [1:0] {IDLE, SCORE, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  ra1, ra0, rb1, rb0, ry3, ry2, ry1, ry0;
  logic [1:0]    step;
  logic [SW-1:0] acc, acc_nx, score_r, best_r;
  logic [15:0]   best_idx_r, ind_r;
  logic [W-1:0]  p_sel, y_sel;
  logic          done_entry;

  function automatic logic [SW-1:0] popcnt(input logic [W-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + SW'(v[i]);
    return c;
  endfunction

  // reference product bit for the current step, from the registered operands
  always_comb begin
    p_sel = '0;
    y_sel = '0;
    case (step)
      2'd0: begin p_sel = ra0 & rb0;                     y_sel = ry0; end
      2'd1: begin p_sel = (ra1 & rb0) ^ (ra0 & rb1);     y_sel = ry1; end
      2'd2: begin p_sel = ra1 & rb1 & ~(ra0 & rb0);      y_sel = ry2; end
      default: begin p_sel = ra1 & ra0 & rb1 & rb0;      y_sel = ry3; end
    endcase
    acc_nx = acc + SW'(W) - popcnt(y_sel ^ p_sel);
  end

  assign done_entry = (state == SCORE) && (step == 2'd3);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SCORE;
      end
      SCORE: begin
        if (step == 2'd3) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= '0;
      acc        <= '0;
      score_r    <= '0;
      best_r     <= '0;
      best_idx_r <= '0;
      ind_r      <= '0;
      ra1 <= '0; ra0 <= '0; rb1 <= '0; rb0 <= '0;
      ry3 <= '0; ry2 <= '0; ry1 <= '0; ry0 <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra1 <= a1; ra0 <= a0; rb1 <= b1; rb0 <= b0;
            ry3 <= y3; ry2 <= y2; ry1 <= y1; ry0 <= y0;
            step <= '0;
            acc  <= '0;
          end
        end
        SCORE: begin
          step <= step + 2'd1;
          acc  <= acc_nx;
          if (step == 2'd3) score_r <= acc_nx;
        end
        default: ;
      endcase
      // clear overrides a coinciding best update
      if (clear_best) begin
        best_r     <= '0;
        best_idx_r <= '0;
        ind_r      <= '0;
      end else if (done_entry) begin
        if (acc_nx > best_r) begin
          best_r     <= acc_nx;
          best_idx_r <= ind_r;
        end
        ind_r <= ind_r + 16'd1;
      end
    end
  end

  assign score      = score_r;
  assign perfect    = (score_r == SW'(4*W));
  assign best_score = best_r;
  assign best_idx   = best_idx_r;
  assign ind_idx    = ind_r;

endmodule

// File: tb/tb_mult2_fitness_scorer.sv
// Directed bench for mult2_fitness_scorer using the packed exhaustive 2x2 vectors.
module tb_mult2_fitness_scorer;

  localparam int W  = 16;
  localparam int SW = 7;

  logic          clk = 1'b0;
  logic          rst, clear_best, in_valid, out_ready;
  logic [W-1:0]  a1, a0, b1, b0, y3, y2, y1, y0;
  logic          in_ready, out_valid, perfect;
  logic [SW-1:0] score, best_score;
  logic [15:0]   best_idx, ind_idx;

  int tests = 0;
  int fails = 0;

  localparam logic [W-1:0] P0 = 16'hA0A0, P1 = 16'h6AC0, P2 = 16'h4C00, P3 = 16'h8000;

  mult2_fitness_scorer #(.W(W)) dut (
    .clk(clk), .rst(rst), .clear_best(clear_best),
    .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .out_valid(out_valid), .out_ready(out_ready),
    .score(score), .perfect(perfect),
    .best_score(best_score), .best_idx(best_idx), .ind_idx(ind_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // present one candidate; scramble y during SCORE to prove the inputs were registered
  task automatic submit(input logic [W-1:0] v3, v2, v1, v0, output int lat);
    y3 = v3; y2 = v2; y1 = v1; y0 = v0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    y3 = ~v3; y2 = ~v2; y1 = ~v1; y0 = ~v0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_score", score, 0);
    chk("rst_perfect", perfect, 0);
    chk("rst_best_score", best_score, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_ind_idx", ind_idx, 0);
  endtask

  task automatic test_perfect();
    int lat;
    do_reset();
    out_ready = 1'b0;
    submit(P3, P2, P1, P0, lat);
    chk("perf_latency", lat, 4);
    chk("perf_score", score, 64);
    chk("perf_perfect", perfect, 1);
    chk("perf_best_score", best_score, 64);
    chk("perf_best_idx", best_idx, 0);
    chk("perf_ind_idx", ind_idx, 1);
    out_ready = 1'b1;
    tick();
    chk("perf_back_idle", in_ready, 1);
  endtask

  task automatic test_sequence();
    int lat;
    do_reset();
    out_ready = 1'b1;
    submit(16'h0000, 16'h0000, 16'h0000, 16'h0000, lat);
    chk("seq0_score", score, 50);
    chk("seq0_perfect", perfect, 0);
    chk("seq0_best_idx", best_idx, 0);
    chk("seq0_best_score", best_score, 50);
    tick();
    submit(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, lat);
    chk("seq1_score", score, 14);
    chk("seq1_best_idx", best_idx, 0);
    chk("seq1_best_score", best_score, 50);
    tick();
    submit(16'h0000, 16'h0000, 16'h0000, 16'h0000, lat);
    chk("seq2_score", score, 50);
    chk("seq2_best_idx_tie", best_idx, 0);
    tick();
    submit(P3, P2, P1, P0, lat);
    chk("seq3_score", score, 64);
    chk("seq3_best_idx", best_idx, 3);
    chk("seq3_best_score", best_score, 64);
    chk("seq3_ind_idx", ind_idx, 4);
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    out_ready = 1'b0;
    submit(16'h0000, 16'h0000, 16'h0000, 16'h0000, lat);
    y3 = P3; y2 = P2; y1 = P1; y0 = P0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_score", score, 50);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_ind_idx_held", ind_idx, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_second_latency", lat, 4);
    chk("bp_second_score", score, 64);
    chk("bp_second_ind_idx", ind_idx, 2);
    chk("bp_second_best_idx", best_idx, 1);
    tick();
  endtask

  task automatic test_clear_on_done();
    int lat;
    do_reset();
    out_ready = 1'b1;
    submit(16'h0000, 16'h0000, 16'h0000, 16'h0000, lat);
    tick();
    submit(P3, P2, P1, P0, lat);
    chk("clr_pre_best_idx", best_idx, 1);
    chk("clr_pre_ind_idx", ind_idx, 2);
    tick();
    out_ready = 1'b0;
    y3 = P3; y2 = P2; y1 = P1; y0 = P0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("clr_still_scoring", out_valid, 0);
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    chk("clr_out_valid", out_valid, 1);
    chk("clr_score", score, 64);
    chk("clr_perfect", perfect, 1);
    chk("clr_best_score", best_score, 0);
    chk("clr_best_idx", best_idx, 0);
    chk("clr_ind_idx", ind_idx, 0);
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    do_reset();
    out_ready = 1'b1;
    submit(P3, P2, P1, P0, lat);
    tick();
    chk("mid_pre_ind_idx", ind_idx, 1);
    y3 = 16'h0000; y2 = 16'h0000; y1 = 16'h0000; y0 = 16'h0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_score", score, 0);
    chk("mid_best_score", best_score, 0);
    chk("mid_best_idx", best_idx, 0);
    chk("mid_ind_idx", ind_idx, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_score", seen, 0);
  endtask

  initial begin
    rst = 1'b1; clear_best = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a1 = 16'hFF00; a0 = 16'hF0F0; b1 = 16'hCCCC; b0 = 16'hAAAA;
    y3 = '0; y2 = '0; y1 = '0; y0 = '0;
    test_reset();
    test_perfect();
    test_sequence();
    test_backpressure();
    test_clear_on_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
